// File: rtl/audio_level_meter_pkg.sv
// Shared definitions for the audio level meter: widths, FSM encoding, threshold
// table and level-to-thermometer mapping (the latter also used by the display stage).
package audio_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int N_LEVELS  = 8;
    localparam int LEVEL_W   = 4;
    localparam int LED_W     = 9;
    localparam int MAX_LEVEL = 8;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        QUANT  = 2'd1,
        UPDATE = 2'd2
    } meter_state_t;

    // T_k = base + k*step, step = (full_scale - base) / n_levels, integer division
    function automatic int unsigned threshold_k(input int unsigned k,
                                                input int unsigned base,
                                                input int unsigned width,
                                                input int unsigned n_levels);
        int unsigned full_scale;
        int unsigned step;
        full_scale = (32'd1 << width) - 32'd1;
        step       = (full_scale - base) / n_levels;
        return base + k * step;
    endfunction

    function automatic logic [LED_W-1:0] level_to_thermo(input logic [LEVEL_W-1:0] level);
        logic [LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < LED_W - 1; i++) begin
            t[i] = (LEVEL_W'(i) < level);
        end
        t[LED_W-1] = (level == LEVEL_W'(MAX_LEVEL));
        return t;
    endfunction

endpackage

// File: rtl/audio_level_meter_if.sv
// Sample input strobe and display outputs of the audio level meter.
interface audio_level_meter_if #(
    parameter int SAMPLE_W = 12
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic [8:0]          led;
    logic [8:0]          num_light;
    logic                window_done;

    modport master (
        output sample_valid, sample,
        input  led, num_light, window_done
    );

    modport slave (
        input  sample_valid, sample,
        output led, num_light, window_done
    );
endinterface

// File: rtl/audio_level_meter_level_quantizer.sv
// Parallel comparator chain against the threshold table plus popcount; the
// resulting level is clamped to 0..MAX_LEVEL.
module level_quantizer #(
    parameter int SAMPLE_W   = 12,
    parameter int BASE_LEVEL = 2048,
    parameter int N_LEVELS   = 8
) (
    input  logic [SAMPLE_W-1:0]          snapshot,
    output logic [audio_pkg::LEVEL_W-1:0] level
);
    import audio_pkg::*;

    logic [N_LEVELS-1:0] above;
    logic [7:0]          cnt;

    for (genvar k = 0; k < N_LEVELS; k++) begin : g_cmp
        localparam logic [SAMPLE_W-1:0] TK =
            SAMPLE_W'(threshold_k(k, BASE_LEVEL, SAMPLE_W, N_LEVELS));
        assign above[k] = (snapshot > TK);
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < N_LEVELS; k++) begin
            cnt = cnt + 8'(above[k]);
        end
        level = (cnt > 8'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : cnt[LEVEL_W-1:0];
    end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak level meter: tracks the peak sample per window, quantises it to
// 0..8 and drives a thermometer LED bar. Optional slow-fall display: AUDIO_LEVEL_PEAK_HOLD_EN.
module audio_level_meter #(
    parameter int SAMPLE_W       = 12,
    parameter int WINDOW_SAMPLES = 4000,
    parameter int BASE_LEVEL     = 2048,
    parameter int N_LEVELS       = 8
) (
    input  logic basys_clock,
    input  logic reset,
    audio_level_meter_if.slave bus
);
    import audio_pkg::*;

    localparam int CNT_W = $clog2(WINDOW_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_SAMPLES - 1);

    meter_state_t        state, state_nxt;
    logic [SAMPLE_W-1:0] peak_acc;
    logic [SAMPLE_W-1:0] peak_nxt;
    logic [SAMPLE_W-1:0] snapshot_p0;
    logic [CNT_W-1:0]    count;
    logic                window_end;
    logic [LEVEL_W-1:0]  level_comb;
    logic [LEVEL_W-1:0]  level_q_p1;
    logic [LEVEL_W-1:0]  disp_level;
    logic [LEVEL_W-1:0]  disp_nxt;
    logic [LED_W-1:0]    led_q;
    logic                window_done_q;

    assign peak_nxt   = (bus.sample > peak_acc) ? bus.sample : peak_acc;
    assign window_end = bus.sample_valid && (count == LAST_CNT);

    // Stage p0: peak accumulation runs independently of the FSM so strobes
    // during QUANT/UPDATE already belong to the next window.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            peak_acc    <= '0;
            count       <= '0;
            snapshot_p0 <= '0;
        end else if (bus.sample_valid) begin
            if (window_end) begin
                snapshot_p0 <= peak_nxt;
                peak_acc    <= '0;
                count       <= '0;
            end else begin
                peak_acc <= peak_nxt;
                count    <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (window_end) state_nxt = QUANT;
            QUANT:   state_nxt = UPDATE;
            UPDATE:  state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    level_quantizer #(
        .SAMPLE_W   (SAMPLE_W),
        .BASE_LEVEL (BASE_LEVEL),
        .N_LEVELS   (N_LEVELS)
    ) u_quant (
        .snapshot (snapshot_p0),
        .level    (level_comb)
    );

    // Stage p1: register the quantised level during QUANT
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            level_q_p1 <= '0;
        end else if (state == QUANT) begin
            level_q_p1 <= level_comb;
        end
    end

    always_comb begin
        disp_nxt = level_q_p1;
`ifdef AUDIO_LEVEL_PEAK_HOLD_EN
        if (level_q_p1 < disp_level) begin
            disp_nxt = disp_level - 1'b1;
        end
`endif
    end

    // Stage p2: display outputs update in UPDATE
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            disp_level    <= '0;
            led_q         <= '0;
            window_done_q <= 1'b0;
        end else begin
            window_done_q <= (state == UPDATE);
            if (state == UPDATE) begin
                disp_level <= disp_nxt;
                led_q      <= level_to_thermo(disp_nxt);
            end
        end
    end

    assign bus.num_light   = {{(LED_W - LEVEL_W){1'b0}}, disp_level};
    assign bus.led         = led_q;
    assign bus.window_done = window_done_q;

endmodule

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
- Sits between the microphone SPI sample capture and the seven-segment/LED display stage.
- Consumes 12-bit microphone samples with a valid strobe and tracks the peak value over a fixed sample window.
- Quantises each window's peak into a volume level 0..8.
- Drives a thermometer LED bar (led) and the binary level (num_light) consumed by the display driver.

Parameters:
- SAMPLE_W, 12, microphone sample width.
- WINDOW_SAMPLES, 4000, samples per measurement window (0.2 s at 20 kHz clk_samp rate); minimum 2.
- BASE_LEVEL, 2048, mic DC midpoint; peaks at or below this give level 0.
- N_LEVELS, 8, number of quantisation steps above BASE_LEVEL.

Ports:
- basys_clock  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; sample is valid this cycle.
- sample  input  SAMPLE_W  unsigned mic sample.
- led  output  9  thermometer bar: led[k-1:0] set for level k, led[8] always equals level==8.
- num_light  output  9  binary level 0..8, zero-extended.
- window_done  output  1  one-cycle pulse when num_light/led update.

Behaviour:
- Interface: one clock, basys_clock. reset is asynchronous and active-high.
- Reset values:
  - led=0, num_light=0, window_done=0.
  - Internal peak accumulator=0, sample counter=0, snapshot=0.
  - State = ACCUM.
- Accumulation:
  - On each sample_valid, peak_acc <= max(peak_acc, sample) and count <= count+1.
  - Cycles without sample_valid hold all accumulator state.
- Window end (sample_valid && count==WINDOW_SAMPLES-1):
  - snapshot <= max(peak_acc, sample).
  - peak_acc <= 0, count <= 0.
  - State -> QUANT.
- QUANT (1 cycle):
  - level_q <= number of thresholds T_k strictly exceeded by snapshot.
  - T_k = BASE_LEVEL + k*STEP for k=0..N_LEVELS-1, where STEP = (2^SAMPLE_W - 1 - BASE_LEVEL)/N_LEVELS (integer, elaboration time).
  - Result is clamped to 0..8.
  - State -> UPDATE.
- UPDATE (1 cycle):
  - num_light, led and window_done=1 are registered.
  - State -> ACCUM.
  - window_done deasserts the next cycle.
- Latency: outputs change exactly 2 cycles after the window-closing sample_valid.
- Sample strobes during QUANT/UPDATE:
  - Accumulate into the new window normally; no sample is dropped.
  - The FSM does not block accumulation.
- Window completing while in QUANT/UPDATE:
  - Only possible when WINDOW_SAMPLES < 3 at 1-cycle strobe spacing.
  - Unsupported; WINDOW_SAMPLES >= 2 and strobe spacing >= 3 cycles are required (clk_samp guarantees this).
- Boundaries:
  - Sample below BASE_LEVEL counts toward the peak but yields level 0 unless exceeded.
  - sample=4095 yields level 8.
  - Count wraps only at window end.
- Reset mid-window discards the partial window. Outputs return to 0 immediately (asynchronous).

Optional Feature:
- Macro: AUDIO_LEVEL_PEAK_HOLD_EN.
- Defined:
  - In UPDATE, num_light takes the new level if it is >= the current display level.
  - Otherwise num_light decrements by exactly 1 per window (slow-fall peak meter).
  - led follows the displayed level.
- Undefined: num_light = new level every window, with no hold.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W, N_LEVELS and LEVEL_W=4.
  - The threshold-table function returning T_k.
  - The level-to-thermometer function (also reusable by the display stage).
  - FSM state encoding: ACCUM, QUANT, UPDATE.
- One natural sub-module, level_quantizer: a parallel comparator chain plus popcount producing level from snapshot, instantiated in QUANT.

Test Plan:
- Reset mid-window: drive samples, assert reset asynchronously -> led=0, num_light=0 same cycle. The next full window starts count from 0.
- Quiet input: WINDOW_SAMPLES=4, samples 2000,2048,1900,2048 -> num_light=0, led=0, window_done pulses once, 2 cycles after the 4th strobe.
- Full scale: one sample 4095 within a window -> num_light=8, led=9'h1FF.
- Threshold edges with STEP=255: peak exactly 2048+255=2303 -> level 1; peak 2304 -> level 2.
- Back-to-back windows: a strobe arrives during the QUANT cycle -> it is counted in the next window. The second window outputs its own peak, not the first's.
- Peak hold (macro defined): window levels 6,2,2,2 -> num_light sequence 6,5,4,3. Macro undefined -> 6,2,2,2.
